ahbram_sub: RTL and testbench

AHB-Lite subordinate RAM that answers the bus manager's transfers: it decodes address and data phases, inserts a configurable number of wait states, supports zero-wait sequential burst beats, and returns a two-cycle ERROR response for out-of-range addresses. It sits in the uncore on the AHB fabric behind the address decoder and is parameterized from the `cvw_t` fields `AHBW`, `RAM_LATENCY`, `BURST_EN`, `PA_BITS` and `UNCORE_RAM_BASE`/`UNCORE_RAM_RANGE`.

---
 rtl/ahbram_sub.sv | 140 ++++++++++++++
 tb/tb_ahbram_sub.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbram_sub.sv
// ============================================================================
// Module      : ahbram_sub
// Description : AHB-Lite subordinate RAM with configurable wait states,
//               zero-wait SEQ burst beats and a two-cycle ERROR response.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahbram_sub #(
    parameter int          AHBW     = 64,
    parameter int          PA_BITS  = 34,
    parameter logic [63:0] BASE     = 64'h80000000,
    parameter logic [63:0] RANGE    = 64'h0FFFF,
    parameter int          LATENCY  = 0,
    parameter int          BURST_EN = 1
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 HSELRam,
    input  wire logic [PA_BITS-1:0]   HADDR,
    input  wire logic                 HWRITE,
    input  wire logic [1:0]           HTRANS,
    input  wire logic [2:0]           HSIZE,
    input  wire logic                 HREADY,
    input  wire logic [AHBW-1:0]      HWDATA,
    input  wire logic [AHBW/8-1:0]    HWSTRB,
    output logic      [AHBW-1:0]      HREADRam,
    output logic                      HREADYRam,
    output logic                      HRESPRam
);

    localparam int                 c_nb    = AHBW / 8;
    localparam int                 c_lb    = $clog2(c_nb);
    localparam int                 c_abits = $clog2(RANGE + 64'd1);
    localparam int                 c_iw    = c_abits - c_lb;
    localparam int                 c_words = 1 << c_iw;
    localparam logic [PA_BITS-1:0] c_mask  = ~RANGE[PA_BITS-1:0];
    localparam logic [PA_BITS-1:0] c_base  = BASE[PA_BITS-1:0];
    localparam logic [3:0]         c_lat   = 4'(LATENCY);
    localparam logic               c_burst = (BURST_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_cnt;
    logic [3:0]        w_next_cnt;
    logic [c_iw-1:0]   r_idx;
    logic              r_write;
    logic              w_capture;
    logic              w_ready;
    logic              w_accept;
    logic              w_in_range;
    logic              w_seq;
    logic [c_iw-1:0]   w_idx;
    logic [AHBW-1:0]   r_mem [c_words];
    logic              w_unused;

    assign w_unused   = ^HSIZE;

    assign w_ready    = (r_state != S_WAIT) && (r_state != S_ERR1);
    // Address phases are only sampled in cycles where this subordinate shows ready.
    assign w_accept   = HSELRam & HREADY & HTRANS[1] & w_ready;
    assign w_seq      = HTRANS[0];
    assign w_in_range = ((HADDR & c_mask) == c_base);
    assign w_idx      = HADDR[c_abits-1:c_lb];

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_capture    = 1'b0;
        case (r_state)
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = S_DATA;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            S_ERR1: begin
                w_next_state = S_ERR2;
            end
            default: begin
                // IDLE, DATA and ERR2 all take a new address phase the same way.
                w_next_state = S_IDLE;
                if (w_accept) begin
                    w_capture = 1'b1;
                    if (!w_in_range) begin
                        w_next_state = S_ERR1;
                    end else if ((c_lat == 4'd0) || (c_burst && w_seq)) begin
                        w_next_state = S_DATA;
                    end else begin
                        w_next_state = S_WAIT;
                        w_next_cnt   = c_lat - 4'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_write <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_capture) begin
                r_idx   <= w_idx;
                r_write <= HWRITE;
            end
        end
    end

    // Storage is intentionally not reset; reset forces IDLE so no write can follow.
    always_ff @(posedge clk) begin
        if ((r_state == S_DATA) && r_write) begin
            for (int i = 0; i < c_nb; i++) begin
                if (HWSTRB[i]) begin
                    r_mem[r_idx][i*8 +: 8] <= HWDATA[i*8 +: 8];
                end
            end
        end
    end

    assign HREADRam  = ((r_state == S_DATA) && !r_write) ? r_mem[r_idx] : '0;
    assign HREADYRam = w_ready;
    assign HRESPRam  = (r_state == S_ERR1) || (r_state == S_ERR2);

endmodule

`default_nettype wire

// File: tb/tb_ahbram_sub.sv
// ============================================================================
// Module      : tb_ahbram_sub
// Description : Directed self-checking bench for ahbram_sub (LATENCY 0/3/5).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahbram_sub;

    localparam logic [33:0] c_base    = 34'h080000000;
    localparam logic [33:0] c_erraddr = 34'h080010000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hsel [3];
    logic [33:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [63:0] hwdata;
    logic [7:0]  hwstrb;
    logic        ready [3];
    logic        resp [3];
    logic [63:0] rd [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ahbram_sub #(.AHBW(64), .PA_BITS(34), .BASE(64'h80000000), .RANGE(64'h0FFFF),
                 .LATENCY(0), .BURST_EN(1)) dut0 (
        .clk(clk), .reset(reset), .HSELRam(hsel[0]), .HADDR(haddr), .HWRITE(hwrite),
        .HTRANS(htrans), .HSIZE(hsize), .HREADY(ready[0]), .HWDATA(hwdata), .HWSTRB(hwstrb),
        .HREADRam(rd[0]), .HREADYRam(ready[0]), .HRESPRam(resp[0]));

    ahbram_sub #(.AHBW(64), .PA_BITS(34), .BASE(64'h80000000), .RANGE(64'h0FFFF),
                 .LATENCY(3), .BURST_EN(1)) dut1 (
        .clk(clk), .reset(reset), .HSELRam(hsel[1]), .HADDR(haddr), .HWRITE(hwrite),
        .HTRANS(htrans), .HSIZE(hsize), .HREADY(ready[1]), .HWDATA(hwdata), .HWSTRB(hwstrb),
        .HREADRam(rd[1]), .HREADYRam(ready[1]), .HRESPRam(resp[1]));

    ahbram_sub #(.AHBW(64), .PA_BITS(34), .BASE(64'h80000000), .RANGE(64'h0FFFF),
                 .LATENCY(5), .BURST_EN(1)) dut2 (
        .clk(clk), .reset(reset), .HSELRam(hsel[2]), .HADDR(haddr), .HWRITE(hwrite),
        .HTRANS(htrans), .HSIZE(hsize), .HREADY(ready[2]), .HWDATA(hwdata), .HWSTRB(hwstrb),
        .HREADRam(rd[2]), .HREADYRam(ready[2]), .HRESPRam(resp[2]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        for (int i = 0; i < 3; i++) hsel[i] = 1'b0;
        haddr  = '0;
        hwrite = 1'b0;
        htrans = 2'b00;
        hsize  = 3'b011;
        hwdata = '0;
        hwstrb = '0;
    endtask

    // Single NONSEQ transfer; returns wait count and the data-phase response.
    task automatic xfer(input int d, input logic [33:0] addr, input logic wr,
                        input logic [63:0] wdata, input logic [7:0] strb,
                        output int waits, output logic [63:0] rdata, output logic rsp);
        hsel[d] = 1'b1;
        haddr   = addr;
        hwrite  = wr;
        htrans  = 2'b10;
        step();
        hsel[d] = 1'b0;
        htrans  = 2'b00;
        hwdata  = wdata;
        hwstrb  = strb;
        waits   = 0;
        while (!ready[d] && waits < 20) begin
            waits++;
            step();
        end
        rdata = rd[d];
        rsp   = resp[d];
        step();
        hwdata = '0;
        hwstrb = '0;
    endtask

    task automatic test_reset();
        idle_bus();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ready[d] !== 1'b1 || resp[d] !== 1'b0 || rd[d] !== 64'd0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got ready=%b resp=%b rd=%h expected 1 0 0",
                         d, ready[d], resp[d], rd[d]);
            end
        end
    endtask

    task automatic test_write_read();
        int w; logic [63:0] r; logic s;
        xfer(0, c_base + 34'h8, 1'b1, 64'hDEADBEEF_01234567, 8'hFF, w, r, s);
        checks++;
        if (w !== 0 || s !== 1'b0) begin
            errors++;
            $display("FAIL wr_lat0: got waits=%0d resp=%b expected 0 0", w, s);
        end
        xfer(0, c_base + 34'h8, 1'b0, 64'd0, 8'h00, w, r, s);
        checks++;
        if (w !== 0 || r !== 64'hDEADBEEF_01234567) begin
            errors++;
            $display("FAIL rd_lat0: got waits=%0d data=%h expected 0 deadbeef01234567", w, r);
        end
        checks++;
        if (rd[0] !== 64'd0) begin
            errors++;
            $display("FAIL rd_idle_zero: got %h expected 0", rd[0]);
        end
    endtask

    task automatic test_latency();
        int w; logic [63:0] r; logic s;
        xfer(1, c_base + 34'h10, 1'b1, 64'hCAFEF00D_12345678, 8'hFF, w, r, s);
        checks++;
        if (w !== 3) begin
            errors++;
            $display("FAIL wr_lat3_waits: got %0d expected 3", w);
        end
        xfer(1, c_base + 34'h10, 1'b0, 64'd0, 8'h00, w, r, s);
        checks++;
        if (w !== 3 || r !== 64'hCAFEF00D_12345678 || s !== 1'b0) begin
            errors++;
            $display("FAIL rd_lat3: got waits=%0d data=%h resp=%b expected 3 cafef00d12345678 0",
                     w, r, s);
        end
    endtask

    task automatic test_burst();
        int w; logic [63:0] r; logic s;
        logic [63:0] vals [4];
        vals[0] = 64'h1111_0000_0000_0001;
        vals[1] = 64'h2222_0000_0000_0002;
        vals[2] = 64'h3333_0000_0000_0003;
        vals[3] = 64'h4444_0000_0000_0004;
        for (int b = 0; b < 4; b++) begin
            xfer(1, c_base + 34'h20 + 34'(8 * b), 1'b1, vals[b], 8'hFF, w, r, s);
        end
        hsel[1] = 1'b1;
        haddr   = c_base + 34'h20;
        hwrite  = 1'b0;
        htrans  = 2'b10;
        step();
        htrans  = 2'b00;
        hsel[1] = 1'b0;
        w = 0;
        while (!ready[1] && w < 20) begin
            w++;
            step();
        end
        checks++;
        if (w !== 3) begin
            errors++;
            $display("FAIL burst_first_waits: got %0d expected 3", w);
        end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (ready[1] !== 1'b1 || rd[1] !== vals[b]) begin
                errors++;
                $display("FAIL burst_beat%0d: got ready=%b data=%h expected 1 %h",
                         b, ready[1], rd[1], vals[b]);
            end
            if (b < 3) begin
                hsel[1] = 1'b1;
                haddr   = c_base + 34'h20 + 34'(8 * (b + 1));
                htrans  = 2'b11;
            end else begin
                hsel[1] = 1'b0;
                htrans  = 2'b00;
            end
            step();
        end
    endtask

    task automatic test_partial();
        int w; logic [63:0] r; logic s;
        xfer(0, c_base + 34'h40, 1'b1, 64'hAAAAAAAA_BBBBBBBB, 8'hFF, w, r, s);
        xfer(0, c_base + 34'h40, 1'b1, 64'h11111111_22222222, 8'h0F, w, r, s);
        xfer(0, c_base + 34'h40, 1'b0, 64'd0, 8'h00, w, r, s);
        checks++;
        if (r !== 64'hAAAAAAAA_22222222) begin
            errors++;
            $display("FAIL partial_write: got %h expected aaaaaaaa22222222", r);
        end
    endtask

    task automatic test_back_to_back();
        int w; logic [63:0] r; logic s;
        xfer(0, c_base + 34'h60, 1'b1, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF, w, r, s);
        hsel[0] = 1'b1;
        haddr   = c_base + 34'h60;
        hwrite  = 1'b1;
        htrans  = 2'b10;
        step();
        checks++;
        if (ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_write_ready: got %b expected 1", ready[0]);
        end
        hwdata = 64'h7654_3210_FEDC_BA98;
        hwstrb = 8'hFF;
        hwrite = 1'b0;
        step();
        idle_bus();
        checks++;
        if (ready[0] !== 1'b1 || rd[0] !== 64'h7654_3210_FEDC_BA98) begin
            errors++;
            $display("FAIL b2b_read_after_write: got ready=%b data=%h expected 1 76543210fedcba98",
                     ready[0], rd[0]);
        end
        step();
    endtask

    task automatic test_error();
        int w; logic [63:0] r; logic s;
        xfer(0, c_base, 1'b1, 64'h5555_6666_7777_8888, 8'hFF, w, r, s);
        hsel[0] = 1'b1;
        haddr   = c_erraddr;
        hwrite  = 1'b1;
        htrans  = 2'b10;
        step();
        hsel[0] = 1'b0;
        htrans  = 2'b00;
        hwdata  = '1;
        hwstrb  = 8'hFF;
        checks++;
        if (ready[0] !== 1'b0 || resp[0] !== 1'b1) begin
            errors++;
            $display("FAIL err_cycle1: got ready=%b resp=%b expected 0 1", ready[0], resp[0]);
        end
        step();
        checks++;
        if (ready[0] !== 1'b1 || resp[0] !== 1'b1) begin
            errors++;
            $display("FAIL err_cycle2: got ready=%b resp=%b expected 1 1", ready[0], resp[0]);
        end
        hwdata = '0;
        hwstrb = '0;
        step();
        checks++;
        if (ready[0] !== 1'b1 || resp[0] !== 1'b0) begin
            errors++;
            $display("FAIL err_done: got ready=%b resp=%b expected 1 0", ready[0], resp[0]);
        end
        xfer(0, c_base, 1'b0, 64'd0, 8'h00, w, r, s);
        checks++;
        if (w !== 0 || s !== 1'b0 || r !== 64'h5555_6666_7777_8888) begin
            errors++;
            $display("FAIL err_mem_unchanged: got waits=%0d resp=%b data=%h expected 0 0 5555666677778888",
                     w, s, r);
        end
    endtask

    task automatic test_reset_mid();
        int w; logic [63:0] r; logic s;
        xfer(2, c_base + 34'h50, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, w, r, s);
        checks++;
        if (w !== 5) begin
            errors++;
            $display("FAIL wr_lat5_waits: got %0d expected 5", w);
        end
        hsel[2] = 1'b1;
        haddr   = c_base + 34'h50;
        hwrite  = 1'b1;
        htrans  = 2'b10;
        step();
        hsel[2] = 1'b0;
        htrans  = 2'b00;
        hwdata  = 64'hFFFF_0000_FFFF_0000;
        hwstrb  = 8'hFF;
        step();
        step();
        checks++;
        if (ready[2] !== 1'b0) begin
            errors++;
            $display("FAIL midwait_ready: got %b expected 0", ready[2]);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (ready[2] !== 1'b1 || resp[2] !== 1'b0 || rd[2] !== 64'd0) begin
            errors++;
            $display("FAIL async_reset: got ready=%b resp=%b rd=%h expected 1 0 0",
                     ready[2], resp[2], rd[2]);
        end
        idle_bus();
        step();
        step();
        reset = 1'b0;
        step();
        xfer(2, c_base + 34'h50, 1'b0, 64'd0, 8'h00, w, r, s);
        checks++;
        if (w !== 5 || r !== 64'h0123_4567_89AB_CDEF) begin
            errors++;
            $display("FAIL reset_abandons_write: got waits=%0d data=%h expected 5 0123456789abcdef",
                     w, r);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_latency();
        test_burst();
        test_partial();
        test_back_to_back();
        test_error();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
